// File: rtl/miriscv_dmem_pkg.sv
// Shared types and widths for the LSU data-memory responder.
// Optional DMEM_BOUND_CHECK_EN adds an out-of-range error strobe in the top and interface.
package miriscv_dmem_pkg;

  localparam int BE_W   = 4;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/miriscv_dmem_resp_if.sv
// Core LSU data bus as seen by the memory responder; slave modport is the responder side.
// data_err_o is only present when DMEM_BOUND_CHECK_EN is defined.
interface miriscv_dmem_resp_if;
  import miriscv_dmem_pkg::*;

  logic              data_req_i;
  logic              data_we_i;
  logic [BE_W-1:0]   data_be_i;
  logic [31:0]       data_addr_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic [DATA_W-1:0] data_rdata_o;
  logic              data_rvalid_o;
  logic              data_busy_o;
`ifdef DMEM_BOUND_CHECK_EN
  logic              data_err_o;
`endif

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_rdata_o, data_rvalid_o, data_busy_o
`ifdef DMEM_BOUND_CHECK_EN
    , data_err_o
`endif
  );

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_rdata_o, data_rvalid_o, data_busy_o
`ifdef DMEM_BOUND_CHECK_EN
    , data_err_o
`endif
  );

endinterface

// File: rtl/miriscv_dmem_array.sv
// Single-port word array, per-byte write enables, registered read (1 cycle); no backpressure.
// A write access clears the read register so write responses return zero data.
module miriscv_dmem_array
  import miriscv_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [AW-1:0]     idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en_i) rdata_d = we_i ? '0 : mem_q[idx_i];
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/miriscv_dmem_resp.sv
// LSU data-memory target: accept, WAIT_STATES+1 cycles to access, one-cycle rvalid; requests ignored while busy.
// DMEM_BOUND_CHECK_EN: out-of-range accesses are suppressed and flagged on data_err_o.
module miriscv_dmem_resp
  import miriscv_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               arstn_i,
  miriscv_dmem_resp_if.slave bus
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rvalid_q, rvalid_d;
  logic              busy_q, busy_d;

  logic [31:0]       offset;
  logic              access;
  logic              oob;
  logic              arr_we;
  logic [BE_W-1:0]   arr_be;
  logic [AW-1:0]     arr_idx;
  logic [DATA_W-1:0] arr_rdata;

  assign offset  = addr_q - BASE_ADDR;
  assign arr_idx = AW'(offset >> 2);

`ifdef DMEM_BOUND_CHECK_EN
  logic err_q, err_d;
  assign oob = (addr_q < BASE_ADDR) || ({1'b0, offset} >= SPAN);
`else
  assign oob = 1'b0;
`endif

  // Out-of-range becomes an empty write: nothing stored and rdata cleared.
  assign arr_we = we_q | oob;
  assign arr_be = oob ? '0 : be_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.data_req_i) begin
          we_d    = bus.data_we_i;
          be_d    = bus.data_be_i;
          addr_d  = bus.data_addr_i;
          wdata_d = bus.data_wdata_i;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rvalid_d = (state_d == RESP);
    busy_d   = (state_d != IDLE);
  end

`ifdef DMEM_BOUND_CHECK_EN
  assign err_d = access & oob;
`endif

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef DMEM_BOUND_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
`ifdef DMEM_BOUND_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  miriscv_dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .en_i    (access),
    .we_i    (arr_we),
    .be_i    (arr_be),
    .idx_i   (arr_idx),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  assign bus.data_rdata_o  = arr_rdata;
  assign bus.data_rvalid_o = rvalid_q;
  assign bus.data_busy_o   = busy_q;
`ifdef DMEM_BOUND_CHECK_EN
  assign bus.data_err_o    = err_q;
`endif

endmodule

// File: tb/tb_miriscv_dmem_resp.sv
// Directed bench for miriscv_dmem_resp: three instances with 0, 3 and 5 wait states.
module tb_miriscv_dmem_resp;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  miriscv_dmem_resp_if b0 ();
  miriscv_dmem_resp_if b3 ();
  miriscv_dmem_resp_if b5 ();

  miriscv_dmem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000))
    u0 (.clk_i(clk), .arstn_i(rst_n), .bus(b0));
  miriscv_dmem_resp #(.DEPTH_WORDS(16), .WAIT_STATES(3), .BASE_ADDR(32'h0000_1000))
    u3 (.clk_i(clk), .arstn_i(rst_n), .bus(b3));
  miriscv_dmem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(5), .BASE_ADDR(32'h0000_0000))
    u5 (.clk_i(clk), .arstn_i(rst_n), .bus(b5));

  int          sel = 0;
  logic        req_v = 1'b0;
  logic        we_v = 1'b0;
  logic [3:0]  be_v = 4'h0;
  logic [31:0] addr_v = '0;
  logic [31:0] wdata_v = '0;

  assign b0.data_req_i = (sel == 0) & req_v;
  assign b3.data_req_i = (sel == 3) & req_v;
  assign b5.data_req_i = (sel == 5) & req_v;
  assign b0.data_we_i = we_v;    assign b3.data_we_i = we_v;    assign b5.data_we_i = we_v;
  assign b0.data_be_i = be_v;    assign b3.data_be_i = be_v;    assign b5.data_be_i = be_v;
  assign b0.data_addr_i = addr_v;  assign b3.data_addr_i = addr_v;  assign b5.data_addr_i = addr_v;
  assign b0.data_wdata_i = wdata_v; assign b3.data_wdata_i = wdata_v; assign b5.data_wdata_i = wdata_v;

  logic        m_rvalid, m_busy, m_err;
  logic [31:0] m_rdata;

  always_comb begin
    m_rvalid = b5.data_rvalid_o;
    m_busy   = b5.data_busy_o;
    m_rdata  = b5.data_rdata_o;
    case (sel)
      0: begin m_rvalid = b0.data_rvalid_o; m_busy = b0.data_busy_o; m_rdata = b0.data_rdata_o; end
      3: begin m_rvalid = b3.data_rvalid_o; m_busy = b3.data_busy_o; m_rdata = b3.data_rdata_o; end
      default: ;
    endcase
  end

`ifdef DMEM_BOUND_CHECK_EN
  assign m_err = (sel == 0) ? b0.data_err_o : (sel == 3) ? b3.data_err_o : b5.data_err_o;
`else
  assign m_err = 1'b0;
`endif

  // One transaction; lat = negedges from accept edge to rvalid (0 = never seen).
  task automatic do_req(input int s, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata,
                        output logic err, output logic rv_after);
    sel = s;
    @(negedge clk);
    req_v = 1'b1; we_v = we; be_v = be; addr_v = addr; wdata_v = wdata;
    @(posedge clk);
    #1 req_v = 1'b0;
    lat = 0; rdata = '0; err = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (m_rvalid) begin
        lat = i; rdata = m_rdata; err = m_err;
        break;
      end
    end
    @(negedge clk);
    rv_after = m_rvalid;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er, rva;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (b0.data_rvalid_o !== 1'b0) begin failures++; $display("FAIL rst_rvalid0 got=%b exp=0", b0.data_rvalid_o); end
    checks++; if (b0.data_busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy0 got=%b exp=0", b0.data_busy_o); end
    checks++; if (b0.data_rdata_o !== 32'h0) begin failures++; $display("FAIL rst_rdata0 got=%h exp=0", b0.data_rdata_o); end
    checks++; if (b3.data_busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy3 got=%b exp=0", b3.data_busy_o); end
    checks++; if (b5.data_rvalid_o !== 1'b0) begin failures++; $display("FAIL rst_rvalid5 got=%b exp=0", b5.data_rvalid_o); end
    checks++; if (b5.data_rdata_o !== 32'h0) begin failures++; $display("FAIL rst_rdata5 got=%h exp=0", b5.data_rdata_o); end
`ifdef DMEM_BOUND_CHECK_EN
    checks++; if (b0.data_err_o !== 1'b0) begin failures++; $display("FAIL rst_err0 got=%b exp=0", b0.data_err_o); end
`endif
  endtask

  task automatic test_write_read();
    do_req(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd, er, rva);
    checks++; if (lat !== 2) begin failures++; $display("FAIL wr_lat got=%0d exp=2", lat); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL wr_rdata got=%h exp=0", rd); end
    checks++; if (rva !== 1'b0) begin failures++; $display("FAIL wr_rvalid_once got=%b exp=0", rva); end
    do_req(0, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd, er, rva);
    checks++; if (lat !== 2) begin failures++; $display("FAIL rd_lat got=%0d exp=2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
    checks++; if (rva !== 1'b0) begin failures++; $display("FAIL rd_rvalid_once got=%b exp=0", rva); end
  endtask

  task automatic test_byte_lanes();
    do_req(0, 1'b1, 4'hF, 32'h20, 32'h11223344, lat, rd, er, rva);
    do_req(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, lat, rd, er, rva);
    do_req(0, 1'b0, 4'h0, 32'h20, 32'h0, lat, rd, er, rva);
    checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL be_merge got=%h exp=11bb33dd", rd); end
    do_req(0, 1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF, lat, rd, er, rva);
    checks++; if (lat !== 2) begin failures++; $display("FAIL be0_lat got=%0d exp=2", lat); end
    do_req(0, 1'b0, 4'hF, 32'h20, 32'h0, lat, rd, er, rva);
    checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL be0_unchanged got=%h exp=11bb33dd", rd); end
  endtask

  task automatic test_addr_lsb();
    do_req(0, 1'b1, 4'hF, 32'h33, 32'h12345678, lat, rd, er, rva);
    do_req(0, 1'b0, 4'h0, 32'h30, 32'h0, lat, rd, er, rva);
    checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL addr_lsb got=%h exp=12345678", rd); end
  endtask

  task automatic test_wait_states();
    logic eb, ev;
    do_req(3, 1'b1, 4'hF, 32'h1008, 32'h0BADCAFE, lat, rd, er, rva);
    checks++; if (lat !== 5) begin failures++; $display("FAIL ws3_lat got=%0d exp=5", lat); end
    // Request held high straight through busy: second accept only after IDLE.
    sel = 3;
    @(negedge clk);
    req_v = 1'b1; we_v = 1'b0; be_v = 4'h0; addr_v = 32'h1008;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      eb = !(k == 5 || k == 11);
      ev = (k == 4 || k == 10);
      checks++; if (m_busy !== eb) begin failures++; $display("FAIL ws3_busy k=%0d got=%b exp=%b", k, m_busy, eb); end
      checks++; if (m_rvalid !== ev) begin failures++; $display("FAIL ws3_rvalid k=%0d got=%b exp=%b", k, m_rvalid, ev); end
      if (ev) begin
        checks++; if (m_rdata !== 32'h0BADCAFE) begin failures++; $display("FAIL ws3_rdata k=%0d got=%h exp=0badcafe", k, m_rdata); end
      end
      if (k == 6) req_v = 1'b0;
    end
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    do_req(5, 1'b1, 4'hF, 32'h40, 32'h01020304, lat, rd, er, rva);
    checks++; if (lat !== 7) begin failures++; $display("FAIL ws5_lat got=%0d exp=7", lat); end
    @(negedge clk);
    req_v = 1'b1; we_v = 1'b1; be_v = 4'hF; addr_v = 32'h40; wdata_v = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_v = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (m_busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", m_busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (m_busy !== 1'b0) begin failures++; $display("FAIL mid_busy_async got=%b exp=0", m_busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_rvalid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL mid_no_rvalid got=%0d exp=0", seen); end
    do_req(5, 1'b0, 4'h0, 32'h40, 32'h0, lat, rd, er, rva);
    checks++; if (rd !== 32'h01020304) begin failures++; $display("FAIL mid_prior_data got=%h exp=01020304", rd); end
  endtask

  task automatic test_bound();
    do_req(0, 1'b1, 4'hF, 32'h0, 32'hA5A5A5A5, lat, rd, er, rva);
    do_req(0, 1'b1, 4'hF, 32'h1000, 32'h55667788, lat, rd, er, rva);
    checks++; if (lat !== 2) begin failures++; $display("FAIL oob_lat got=%0d exp=2", lat); end
`ifdef DMEM_BOUND_CHECK_EN
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL oob_err got=%b exp=1", er); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL oob_rdata got=%h exp=0", rd); end
    do_req(0, 1'b0, 4'h0, 32'h0, 32'h0, lat, rd, er, rva);
    checks++; if (rd !== 32'hA5A5A5A5) begin failures++; $display("FAIL oob_word0 got=%h exp=a5a5a5a5", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL inb_err got=%b exp=0", er); end
`else
    do_req(0, 1'b0, 4'h0, 32'h0, 32'h0, lat, rd, er, rva);
    checks++; if (rd !== 32'h55667788) begin failures++; $display("FAIL wrap_word0 got=%h exp=55667788", rd); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_addr_lsb();
    test_wait_states();
    test_reset_mid_wait();
    test_bound();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/miriscv_dmem_resp.md
# miriscv_dmem_resp

Data-memory responder: the target end of the core's LSU data bus (req/we/be/addr/wdata). Accepts one request at a time, inserts a configurable number of wait states, performs a byte-lane-masked write or a full-word read on an internal word array, and returns a single-cycle response strobe with read data. Sits between the core's data port and the on-chip data RAM and replaces the zero-latency RAM model.

## Interface
Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, ≥ 4
- WAIT_STATES, 0, extra cycles between accept and access; 0..15
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4

Ports:
- clk_i  in  1  clock, rising edge
- arstn_i  in  1  reset; one clock; reset is asynchronous and active-low
- data_req_i  in  1  request valid
- data_we_i  in  1  1 = write, 0 = read
- data_be_i  in  4  byte enables, bit i ↔ wdata[8i+7:8i]
- data_addr_i  in  32  byte address
- data_wdata_i  in  32  write data
- data_rdata_o  out  32  read data, valid while data_rvalid_o = 1
- data_rvalid_o  out  1  response strobe, exactly one cycle per accepted request
- data_busy_o  out  1  request in flight; requests ignored while high
- data_err_o  out  1  access error (present only with DMEM_BOUND_CHECK_EN)

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: data_req_i = 1 at a rising edge → latch we/be/addr/wdata, load cnt = WAIT_STATES, go WAIT.
- WAIT: cnt ≠ 0 → cnt−1, stay. cnt = 0 → perform access at this edge, go RESP.
- Access: index = (addr − BASE_ADDR) >> 2, low log2(DEPTH_WORDS) bits used; addr[1:0] ignored.
  - Write: for each be[i] = 1, byte i of word ← wdata byte i; be = 4'b0000 changes nothing but still responds. data_rdata_o = 0.
  - Read: data_rdata_o ← full word, be ignored.
- RESP: data_rvalid_o = 1 for this cycle only; next edge → IDLE unconditionally. A data_req_i high during RESP is not accepted; initiator drops or re-presents req after seeing rvalid.
- data_busy_o = 1 in WAIT and RESP, 0 in IDLE.
- Inputs are sampled only at the accept edge; changes during WAIT/RESP have no effect.
- Memory contents are not reset; power-up contents undefined (simulation may preload).

## Timing
- Reset values: state IDLE, data_rdata_o = 0, data_rvalid_o = 0, data_busy_o = 0, data_err_o = 0, cnt = 0.
- Accept at edge N → access at edge N+1+WAIT_STATES → rvalid high during the cycle after that edge.
- Minimum request-to-request spacing: WAIT_STATES + 3 cycles.
- Read-after-write to same word: second read returns newly written bytes (write completes before RESP).
- Reset asserted in WAIT: transaction aborted, pending write not performed, no rvalid. Reset in RESP: rvalid drops immediately (asynchronous).
- All outputs registered; no combinational input→output path.

## Configuration
- Macro DMEM_BOUND_CHECK_EN.
- Defined: data_err_o exists; addr < BASE_ADDR or addr ≥ BASE_ADDR + DEPTH_WORDS*4 → no write, data_rdata_o = 0, data_err_o = 1 in the same cycle as data_rvalid_o; otherwise data_err_o = 0.
- Not defined: port absent; out-of-range addresses wrap modulo DEPTH_WORDS through the index truncation; normal access performed.

## Structure
- Package miriscv_dmem_pkg: FSM state enum (IDLE, WAIT, RESP), BE_W = 4, DATA_W = 32, cnt width constant (4 bits).
- Sub-module miriscv_dmem_array: single-port synchronous word array with per-byte write enables and registered read; FSM and bound check stay in the top.

## Test plan
- WAIT_STATES=0: write addr 0x10, wdata 0xDEADBEEF, be 4'hF; then read 0x10 → rvalid 2 cycles after each accept, read returns 0xDEADBEEF.
- Byte lanes: word 0x20 = 0x11223344, write wdata 0xAABBCCDD be 4'b0101 → read 0x11BB33DD; be 4'b0000 → word unchanged, rvalid still pulses.
- WAIT_STATES=3: read accepted at edge N → busy high cycles N+1..N+5, rvalid only in the cycle after edge N+4; second req held high during busy accepted only after return to IDLE.
- Reset mid-WAIT (WAIT_STATES=5): write 0xCAFEF00D to 0x40, arstn_i low at accept+2 → no rvalid, busy 0 immediately, later read of 0x40 returns prior contents.
- DMEM_BOUND_CHECK_EN, DEPTH_WORDS=1024: write to 0x1000 → rvalid with data_err_o = 1, rdata 0, word 0 unchanged; without macro same write lands at word 0.
- addr[1:0] ignored: write 0x12345678 to 0x33, read 0x30 → 0x12345678.
